// File: rtl/pair_cfg_if.sv
// Configuration stream bundle for the pair atom loader: one framed 32-bit
// word per valid/ready transfer, plus a side-band abort.
interface pair_cfg_if;
  logic        i__cfg_valid;
  logic [31:0] i__cfg_data;
  logic        o__cfg_ready;
  logic        i__cfg_abort;

  modport master (
    output i__cfg_valid,
    output i__cfg_data,
    output i__cfg_abort,
    input  o__cfg_ready
  );

  modport slave (
    input  i__cfg_valid,
    input  i__cfg_data,
    input  i__cfg_abort,
    output o__cfg_ready
  );
endinterface

// File: rtl/pair_cfg_loader.sv
// Configuration writer for the pair stateful atom. A framed stream
// (header, NUM_CONS constants, SELA, SELB) is collected into a shadow bank.
// The bank is copied to the active outputs in a single COMMIT cycle, so the
// atom only ever sees complete configurations.
module pair_cfg_loader #(
  parameter int          NUM_CONS = 19,
  parameter logic [15:0] MAGIC    = 16'hA70B
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pair_cfg_if.slave             cfg,
  output logic [32*NUM_CONS-1:0] o__cons,
  output logic [16:0]           o__sel_bool,
  output logic [31:0]           o__sel_2b,
  output logic [5:0]            o__rel_op,
  output logic [7:0]            o__epoch,
  output logic                  o__busy,
  output logic                  o__err
);

  localparam int CNT_W = $clog2(NUM_CONS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CONS,
    LOAD_SELA,
    LOAD_SELB,
    COMMIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q;
  logic             busy_q;
  logic             err_q, err_d;

  // Active (committed) configuration
  logic [32*NUM_CONS-1:0] cons_q;
  logic [16:0]            sel_bool_q;
  logic [31:0]            sel_2b_q;
  logic [5:0]             rel_op_q;
  logic [7:0]             epoch_q;

  // Shadow bank; only reaches the outputs through COMMIT
  logic [31:0] shad_cons_q [NUM_CONS];
  logic [16:0] shad_bool_q;
  logic [5:0]  shad_rel_q;
  logic [31:0] shad_2b_q;

  logic xfer;
  logic wr_cons, wr_sela, wr_selb;
  logic do_commit;

  // Header is valid when the magic matches and the length field equals the
  // frame length after the header (constants + SELA + SELB).
  function automatic logic hdr_ok(input logic [31:0] w);
    return (w[31:16] == MAGIC) && (w[7:0] == 8'(NUM_CONS + 2));
  endfunction

  // ready is a registered copy of "next state is not COMMIT", so it is low
  // during reset and only rises on the first edge after reset release.
  assign xfer             = cfg.i__cfg_valid && ready_q;
  assign cfg.o__cfg_ready = ready_q;
  assign do_commit        = (state_q == COMMIT);

  // Next-state and shadow write strobes; abort wins over a word offered in
  // the same cycle while loading.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    wr_cons = 1'b0;
    wr_sela = 1'b0;
    wr_selb = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (hdr_ok(cfg.i__cfg_data)) begin
            state_d = LOAD_CONS;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_CONS: begin
        if (cfg.i__cfg_abort) begin
          state_d = IDLE;
        end else if (xfer) begin
          wr_cons = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_CONS - 1)) begin
            state_d = LOAD_SELA;
          end
        end
      end
      LOAD_SELA: begin
        if (cfg.i__cfg_abort) begin
          state_d = IDLE;
        end else if (xfer) begin
          if (cfg.i__cfg_data[31:23] != 9'd0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            wr_sela = 1'b1;
            state_d = LOAD_SELB;
          end
        end
      end
      LOAD_SELB: begin
        if (cfg.i__cfg_abort) begin
          state_d = IDLE;
        end else if (xfer) begin
          wr_selb = 1'b1;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state, registered handshake/status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d != COMMIT);
      busy_q  <= (state_d != IDLE);
      err_q   <= err_d;
    end
  end

  // Shadow bank capture; contents are don't-care until a full frame lands
  always_ff @(posedge clk) begin
    if (wr_cons) begin
      shad_cons_q[cnt_q] <= cfg.i__cfg_data;
    end
    if (wr_sela) begin
      shad_bool_q <= cfg.i__cfg_data[16:0];
      shad_rel_q  <= cfg.i__cfg_data[22:17];
    end
    if (wr_selb) begin
      shad_2b_q <= cfg.i__cfg_data;
    end
  end

  // Atomic commit of the whole shadow bank and epoch bump
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cons_q     <= '0;
      sel_bool_q <= '0;
      sel_2b_q   <= '0;
      rel_op_q   <= '0;
      epoch_q    <= '0;
    end else if (do_commit) begin
      for (int k = 0; k < NUM_CONS; k++) begin
        cons_q[32*k +: 32] <= shad_cons_q[k];
      end
      sel_bool_q <= shad_bool_q;
      sel_2b_q   <= shad_2b_q;
      rel_op_q   <= shad_rel_q;
      epoch_q    <= epoch_q + 8'd1;
    end
  end

  assign o__cons     = cons_q;
  assign o__sel_bool = sel_bool_q;
  assign o__sel_2b   = sel_2b_q;
  assign o__rel_op   = rel_op_q;
  assign o__epoch    = epoch_q;
  assign o__busy     = busy_q;
  assign o__err      = err_q;

endmodule

// File: tb/tb_pair_cfg_loader.sv
// Bench for pair_cfg_loader: frames are driven through the interface, the
// expected committed configuration is queued when SELB is sent and checked
// by a monitor whenever the epoch moves.
module tb_pair_cfg_loader;

  localparam int NC = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pair_cfg_if cfg();

  logic [32*NC-1:0] o__cons;
  logic [16:0]      o__sel_bool;
  logic [31:0]      o__sel_2b;
  logic [5:0]       o__rel_op;
  logic [7:0]       o__epoch;
  logic             o__busy;
  logic             o__err;

  pair_cfg_loader #(.NUM_CONS(NC), .MAGIC(16'hA70B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg         (cfg),
    .o__cons     (o__cons),
    .o__sel_bool (o__sel_bool),
    .o__sel_2b   (o__sel_2b),
    .o__rel_op   (o__rel_op),
    .o__epoch    (o__epoch),
    .o__busy     (o__busy),
    .o__err      (o__err)
  );

  typedef struct {
    logic [32*NC-1:0] cons;
    logic [16:0]      sb;
    logic [31:0]      s2;
    logic [5:0]       ro;
    logic [7:0]       ep;
  } exp_t;

  exp_t       sbq[$];
  exp_t       last;
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  int         wait_cnt = 0;
  logic [7:0] exp_epoch = 8'd0;
  logic [7:0] prev_ep = 8'd0;
  bit         wrap_seen = 1'b0;

  // Commit monitor: each epoch change pops one expected configuration
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_ep = o__epoch;
    end else if (o__epoch !== prev_ep) begin
      if (prev_ep == 8'd255 && o__epoch == 8'd0) wrap_seen = 1'b1;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_commit epoch=%0d required no commit", o__epoch);
      end else begin
        mon_e = sbq.pop_front();
        if (o__epoch !== mon_e.ep) begin
          bad++;
          $display("FAIL commit_epoch got=%0d exp=%0d", o__epoch, mon_e.ep);
        end
        total++;
        if (o__cons !== mon_e.cons) begin
          bad++;
          $display("FAIL commit_cons got=%h exp=%h", o__cons, mon_e.cons);
        end
        total++;
        if (o__sel_bool !== mon_e.sb || o__rel_op !== mon_e.ro) begin
          bad++;
          $display("FAIL commit_sela got=%h/%h exp=%h/%h", o__sel_bool, o__rel_op, mon_e.sb, mon_e.ro);
        end
        total++;
        if (o__sel_2b !== mon_e.s2) begin
          bad++;
          $display("FAIL commit_selb got=%h exp=%h", o__sel_2b, mon_e.s2);
        end
        last = mon_e;
      end
      prev_ep = o__epoch;
    end
  end

  function automatic int gap(input bit en);
    if (!en) return 0;
    return ($urandom_range(1, 0) == 1) ? int'($urandom_range(3, 1)) : 0;
  endfunction

  function automatic logic [32*NC-1:0] rand_cons();
    logic [32*NC-1:0] c;
    for (int k = 0; k < NC; k++) c[32*k +: 32] = $urandom;
    return c;
  endfunction

  // Offer one word and hold it until it transfers (bounded)
  task automatic send_word(input logic [31:0] d, input int g);
    logic r;
    bit   ok;
    if (g > 0) begin
      cfg.i__cfg_valid = 1'b0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    cfg.i__cfg_valid = 1'b1;
    cfg.i__cfg_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r = cfg.o__cfg_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
      wait_cnt++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout ready=0 required=1");
    end
  endtask

  task automatic send_hdr_cons(input logic [32*NC-1:0] c, input bit gaps, input int n,
                               input bit abort_hdr);
    logic [31:0] hdr;
    hdr = {16'hA70B, 8'($urandom_range(255, 0)), 8'd21};
    cfg.i__cfg_abort = abort_hdr;
    send_word(hdr, gap(gaps));
    cfg.i__cfg_abort = 1'b0;
    for (int k = 0; k < n; k++) send_word(c[32*k +: 32], gap(gaps));
  endtask

  task automatic send_frame(input logic [32*NC-1:0] c, input logic [31:0] sela,
                            input logic [31:0] selb, input bit gaps, input bit abort_hdr);
    exp_t e;
    send_hdr_cons(c, gaps, NC, abort_hdr);
    send_word(sela, gap(gaps));
    send_word(selb, gap(gaps));
    exp_epoch = exp_epoch + 8'd1;
    e.cons = c;
    e.sb   = sela[16:0];
    e.ro   = sela[22:17];
    e.s2   = selb;
    e.ep   = exp_epoch;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    cfg.i__cfg_valid = 1'b0;
    cfg.i__cfg_abort = 1'b0;
    cfg.i__cfg_data  = 32'd0;
    rst_n = 1'b0;
    last.cons = '0; last.sb = '0; last.s2 = '0; last.ro = '0; last.ep = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cfg.o__cfg_ready !== 1'b0 || o__busy !== 1'b0 || o__err !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got ready/busy/err=%b%b%b exp=000", cfg.o__cfg_ready, o__busy, o__err);
    end
    total++;
    if (o__epoch !== 8'd0 || o__cons !== '0 || o__sel_bool !== '0 || o__sel_2b !== '0 || o__rel_op !== '0) begin
      bad++;
      $display("FAIL reset_cfg got epoch=%0d sb=%h s2=%h ro=%h exp all 0", o__epoch, o__sel_bool, o__sel_2b, o__rel_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (cfg.o__cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge got=%b exp=0", cfg.o__cfg_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (cfg.o__cfg_ready !== 1'b1 || o__busy !== 1'b0) begin
      bad++;
      $display("FAIL ready_after_edge got ready/busy=%b%b exp=10", cfg.o__cfg_ready, o__busy);
    end
  endtask

  task automatic test_basic();
    logic [32*NC-1:0] c;
    for (int k = 0; k < NC; k++) c[32*k +: 32] = 32'h100 + 32'(k + 1);
    send_frame(c, 32'h007FFFFF, 32'hE4E4E4E4, 1'b0, 1'b0);
    cfg.i__cfg_valid = 1'b0;
    total++;
    if (cfg.o__cfg_ready !== 1'b0 || o__busy !== 1'b1 || o__epoch !== 8'd0) begin
      bad++;
      $display("FAIL commit_cycle got ready/busy=%b%b epoch=%0d exp=01 epoch=0", cfg.o__cfg_ready, o__busy, o__epoch);
    end
    @(posedge clk);
    #1;
    total++;
    if (o__cons[31:0] !== 32'h101 || o__cons[32*18 +: 32] !== 32'h113) begin
      bad++;
      $display("FAIL basic_cons got=%h/%h exp=101/113", o__cons[31:0], o__cons[32*18 +: 32]);
    end
    total++;
    if (o__sel_bool !== 17'h1FFFF || o__rel_op !== 6'h3F || o__sel_2b !== 32'hE4E4E4E4) begin
      bad++;
      $display("FAIL basic_sel got=%h/%h/%h exp=1ffff/3f/e4e4e4e4", o__sel_bool, o__rel_op, o__sel_2b);
    end
    total++;
    if (o__epoch !== 8'd1 || o__busy !== 1'b0 || cfg.o__cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_after got epoch=%0d busy=%b ready=%b exp 1/0/1", o__epoch, o__busy, cfg.o__cfg_ready);
    end
  endtask

  task automatic test_bad_header();
    logic [7:0]  ep0;
    logic [31:0] hdrs [2];
    hdrs[0] = 32'hA70C0015;
    hdrs[1] = 32'hA70B0014;
    for (int h = 0; h < 2; h++) begin
      ep0 = o__epoch;
      send_word(hdrs[h], 0);
      cfg.i__cfg_valid = 1'b0;
      total++;
      if (o__err !== 1'b1 || o__busy !== 1'b0) begin
        bad++;
        $display("FAIL bad_hdr_err hdr=%h got err/busy=%b%b exp=10", hdrs[h], o__err, o__busy);
      end
      @(posedge clk);
      #1;
      total++;
      if (o__err !== 1'b0 || o__epoch !== ep0 || o__cons !== last.cons) begin
        bad++;
        $display("FAIL bad_hdr_after got err=%b epoch=%0d exp err=0 epoch=%0d", o__err, o__epoch, ep0);
      end
    end
    ep0 = o__epoch;
    send_frame(rand_cons(), $urandom & 32'h007FFFFF, $urandom, 1'b0, 1'b0);
    cfg.i__cfg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (o__epoch !== ep0 + 8'd1 || sbq.size() != 0) begin
      bad++;
      $display("FAIL bad_hdr_recover got epoch=%0d pending=%0d exp epoch=%0d pending=0", o__epoch, sbq.size(), ep0 + 8'd1);
    end
  endtask

  task automatic test_bad_sela();
    logic [7:0] ep0;
    ep0 = o__epoch;
    send_hdr_cons(rand_cons(), 1'b0, NC, 1'b0);
    send_word(32'h00800000, 0);
    cfg.i__cfg_valid = 1'b0;
    total++;
    if (o__err !== 1'b1 || o__busy !== 1'b0) begin
      bad++;
      $display("FAIL bad_sela_err got err/busy=%b%b exp=10", o__err, o__busy);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (o__err !== 1'b0 || o__epoch !== ep0 || o__cons !== last.cons ||
        o__sel_bool !== last.sb || o__sel_2b !== last.s2 || o__rel_op !== last.ro) begin
      bad++;
      $display("FAIL bad_sela_kept got err=%b epoch=%0d sb=%h exp err=0 epoch=%0d sb=%h", o__err, o__epoch, o__sel_bool, ep0, last.sb);
    end
  endtask

  task automatic test_abort();
    logic [7:0] ep0;
    ep0 = o__epoch;
    send_hdr_cons(rand_cons(), 1'b0, 10, 1'b0);
    cfg.i__cfg_abort = 1'b1;
    cfg.i__cfg_valid = 1'b1;
    cfg.i__cfg_data  = $urandom;
    @(posedge clk);
    #1;
    cfg.i__cfg_abort = 1'b0;
    cfg.i__cfg_valid = 1'b0;
    total++;
    if (o__busy !== 1'b0 || o__err !== 1'b0 || cfg.o__cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_state got busy/err/ready=%b%b%b exp=001", o__busy, o__err, cfg.o__cfg_ready);
    end
    total++;
    if (o__epoch !== ep0 || o__cons !== last.cons) begin
      bad++;
      $display("FAIL abort_kept got epoch=%0d exp=%0d", o__epoch, ep0);
    end
    // abort while IDLE must not block the header
    send_frame(rand_cons(), $urandom & 32'h007FFFFF, $urandom, 1'b0, 1'b1);
    cfg.i__cfg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (o__epoch !== ep0 + 8'd1 || sbq.size() != 0) begin
      bad++;
      $display("FAIL abort_recover got epoch=%0d pending=%0d exp epoch=%0d pending=0", o__epoch, sbq.size(), ep0 + 8'd1);
    end
  endtask

  task automatic test_gaps();
    logic [32*NC-1:0] c;
    logic [31:0]      sa, sb;
    c  = rand_cons();
    sa = $urandom & 32'h007FFFFF;
    sb = $urandom;
    wait_cnt = 0;
    send_frame(c, sa, sb, 1'b1, 1'b0);
    cfg.i__cfg_valid = 1'b0;
    total++;
    if (wait_cnt != 0) begin
      bad++;
      $display("FAIL gaps_ready_low got=%0d cycles exp=0", wait_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    send_frame(c, sa, sb, 1'b0, 1'b0);
    cfg.i__cfg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (o__cons !== c || o__sel_2b !== sb || sbq.size() != 0) begin
      bad++;
      $display("FAIL gaps_result got s2=%h pending=%0d exp s2=%h pending=0", o__sel_2b, sbq.size(), sb);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ep0;
    ep0 = o__epoch;
    wait_cnt  = 0;
    wrap_seen = 1'b0;
    for (int f = 0; f < 256; f++) begin
      send_frame(rand_cons(), $urandom & 32'h007FFFFF, $urandom, 1'b0, 1'b0);
    end
    cfg.i__cfg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (wait_cnt != 255) begin
      bad++;
      $display("FAIL b2b_stall_cycles got=%0d exp=255", wait_cnt);
    end
    total++;
    if (o__epoch !== ep0 || wrap_seen !== 1'b1 || sbq.size() != 0) begin
      bad++;
      $display("FAIL b2b_wrap got epoch=%0d wrap=%b pending=%0d exp epoch=%0d wrap=1 pending=0", o__epoch, wrap_seen, sbq.size(), ep0);
    end
  endtask

  task automatic test_reset_in_commit();
    send_frame(rand_cons(), $urandom & 32'h007FFFFF, $urandom, 1'b0, 1'b0);
    cfg.i__cfg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sbq.delete();
    exp_epoch = 8'd0;
    total++;
    if (o__epoch !== 8'd0 || o__cons !== '0 || o__sel_bool !== '0 || o__sel_2b !== '0 ||
        o__rel_op !== '0 || o__busy !== 1'b0 || cfg.o__cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got epoch=%0d busy=%b ready=%b s2=%h exp all 0", o__epoch, o__busy, cfg.o__cfg_ready, o__sel_2b);
    end
    @(posedge clk);
    #1;
    total++;
    if (o__epoch !== 8'd0 || o__cons !== '0) begin
      bad++;
      $display("FAIL reset_hold got epoch=%0d exp=0", o__epoch);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (cfg.o__cfg_ready !== 1'b1 || o__busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset got ready/busy=%b%b exp=10", cfg.o__cfg_ready, o__busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_header();
    test_bad_sela();
    test_abort();
    test_gaps();
    test_back_to_back();
    test_reset_in_commit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
